// File: rtl/uart_accel_pkg.sv
// Shared definitions for the UART arithmetic accelerator: opcodes, packet sizes, FSM states.
package uart_accel_pkg;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_MUL = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;
    localparam logic [7:0] OP_SLT = 8'h06;

    localparam int unsigned DATA_W            = 32;
    localparam int unsigned PKT_OPERAND_BYTES = 4;
    localparam int unsigned RES_BYTES         = 4;
    localparam int unsigned CNT_W             = 3;

    typedef enum logic [2:0] {
        S_OPC  = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_TX   = 3'd4
    } pkt_state_e;

endpackage

// File: rtl/arith_alu.sv
// Combinational 32-bit ALU for the accelerator opcodes; unknown opcodes yield all ones.
module arith_alu
    import uart_accel_pkg::*;
(
    input  logic [7:0]        i_opcode,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result_c
);

    always_comb begin
        o_result_c = '1;
        case (i_opcode)
            OP_ADD:  o_result_c = i_a + i_b;
            OP_SUB:  o_result_c = i_a - i_b;
            OP_MUL:  o_result_c = i_a * i_b;
            OP_AND:  o_result_c = i_a & i_b;
            OP_OR:   o_result_c = i_a | i_b;
            OP_XOR:  o_result_c = i_a ^ i_b;
            OP_SLT:  o_result_c = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: o_result_c = '1;
        endcase
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing errors dropped, one-cycle done pulse per good byte.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       iRst,
    input  logic       iClk,
    input  logic       iRxSerial,
    output logic [7:0] oRxByte,
    output logic       oRxDone
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    rx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            oRxByte <= '0;
            oRxDone <= 1'b0;
        end else begin
            oRxDone <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!iRxSerial) r_state <= RX_START;
                end
                RX_START: begin
                    if (r_cnt == CNT_W'(HALF_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= iRxSerial ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {iRxSerial, r_shift[7:1]};
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                        else               r_bit   <= r_bit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt <= '0;
                        if (iRxSerial) begin
                            oRxByte <= r_shift;
                            oRxDone <= 1'b1;
                            r_state <= RX_IDLE;
                        end else begin
                            r_state <= RX_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // A low stop bit leaves the line low; re-arm only once it idles high again.
                RX_WAIT_HIGH: begin
                    if (iRxSerial) r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; busy drops in the final stop-bit cycle so a new byte can follow back-to-back.
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       iRst,
    input  logic       iClk,
    input  logic       iTxStart,
    input  logic [7:0] iTxByte,
    output logic       oTxSerial,
    output logic       oTxBusy,
    output logic       oTxDone
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    tx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state   <= TX_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            oTxSerial <= 1'b1;
            oTxBusy   <= 1'b0;
            oTxDone   <= 1'b0;
        end else begin
            oTxDone <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    oTxSerial <= 1'b1;
                    if (iTxStart) begin
                        r_shift   <= iTxByte;
                        oTxSerial <= 1'b0;
                        oTxBusy   <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt     <= '0;
                        r_bit     <= '0;
                        oTxSerial <= r_shift[0];
                        r_state   <= TX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            oTxSerial <= 1'b1;
                            r_state   <= TX_STOP;
                        end else begin
                            r_bit     <= r_bit + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            oTxSerial <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt <= '0;
                        if (iTxStart) begin
                            r_shift   <= iTxByte;
                            oTxSerial <= 1'b0;
                            oTxBusy   <= 1'b1;
                            r_state   <= TX_START;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        // Announce completion one cycle early so the next start lands on the bit boundary.
                        if (r_cnt == CNT_W'(CLKS_PER_BIT - 2)) begin
                            oTxBusy <= 1'b0;
                            oTxDone <= 1'b1;
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_accel_top.sv
// UART arithmetic accelerator: 9-byte command packet in, 4-byte result out, MSB first.
module uart_accel_top
    import uart_accel_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iRx,
    output logic oTx
);

    logic              r_rx_meta;
    logic              r_rx_sync;
    logic [7:0]        w_rx_byte;
    logic              w_rx_done;
    logic              w_tx_start;
    logic [7:0]        w_tx_byte;
    logic              w_tx_busy;
    logic              w_tx_done;
    logic [DATA_W-1:0] w_alu_result;

    pkt_state_e        r_state;
    logic [7:0]        r_opcode;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_tx_launched;

    // Two-flop synchroniser, idles high like the line itself.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= iRx;
            r_rx_sync <= r_rx_meta;
        end
    end

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .iRst      (iRst),
        .iClk      (iClk),
        .iRxSerial (r_rx_sync),
        .oRxByte   (w_rx_byte),
        .oRxDone   (w_rx_done)
    );

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .iRst      (iRst),
        .iClk      (iClk),
        .iTxStart  (w_tx_start),
        .iTxByte   (w_tx_byte),
        .oTxSerial (oTx),
        .oTxBusy   (w_tx_busy),
        .oTxDone   (w_tx_done)
    );

    arith_alu u_alu (
        .i_opcode   (r_opcode),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_result_c (w_alu_result)
    );

    // Launch the next result byte whenever the transmitter can take it.
    assign w_tx_start = (r_state == S_TX) && !w_tx_busy && (r_tx_launched < CNT_W'(RES_BYTES));

    always_comb begin
        w_tx_byte = r_result[31:24];
        case (r_tx_launched[1:0])
            2'd1:    w_tx_byte = r_result[23:16];
            2'd2:    w_tx_byte = r_result[15:8];
            2'd3:    w_tx_byte = r_result[7:0];
            default: w_tx_byte = r_result[31:24];
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state       <= S_OPC;
            r_opcode      <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_cnt         <= '0;
            r_tx_launched <= '0;
        end else begin
            case (r_state)
                S_OPC: begin
                    if (w_rx_done) begin
                        r_opcode <= w_rx_byte;
                        r_cnt    <= '0;
                        r_state  <= S_A;
                    end
                end
                S_A: begin
                    if (w_rx_done) begin
                        r_a <= {r_a[DATA_W-9:0], w_rx_byte};
                        if (r_cnt == CNT_W'(PKT_OPERAND_BYTES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_B;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_B: begin
                    if (w_rx_done) begin
                        r_b <= {r_b[DATA_W-9:0], w_rx_byte};
                        if (r_cnt == CNT_W'(PKT_OPERAND_BYTES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_EXEC;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_EXEC: begin
                    r_result      <= w_alu_result;
                    r_cnt         <= '0;
                    r_tx_launched <= '0;
                    r_state       <= S_TX;
                end
                // Received bytes are ignored here; r_cnt counts completed result bytes.
                S_TX: begin
                    if (w_tx_start) r_tx_launched <= r_tx_launched + CNT_W'(1);
                    if (w_tx_done) begin
                        if (r_cnt == CNT_W'(RES_BYTES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_OPC;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_OPC;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_accel_top.sv
// Directed plus random bench for uart_accel_top with a behavioural serial decoder and reference ALU.
module tb_uart_accel_top;

    localparam int unsigned CLK_FREQ  = 100;
    localparam int unsigned BAUD_RATE = 10;
    localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CLK_T     = 10;
    localparam int unsigned BIT_T     = CPB * CLK_T;
    // Stop bit seen at mid-bit, then synchroniser/receiver and a 3-cycle response.
    localparam int unsigned LAT_MAX   = BIT_T / 2 + 6 * CLK_T;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    time        rx_t[$];
    int         dec_err = 0;
    time        last_stop_t = 0;

    uart_accel_top #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .iClk (clk),
        .iRst (rst),
        .iRx  (rx),
        .oTx  (tx)
    );

    always #5 clk = ~clk;

    // Independent 8N1 decoder of the DUT's serial output.
    initial begin : decoder
        logic [7:0] b;
        time        t0;
        forever begin
            @(negedge tx);
            t0 = $time;
            #(BIT_T / 2);
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    #(BIT_T);
                    b[i] = tx;
                end
                #(BIT_T);
                if (tx === 1'b1) begin
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                end else begin
                    dec_err++;
                end
            end else begin
                dec_err++;
            end
        end
    end

    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            8'h00: return a + b;
            8'h01: return a - b;
            8'h02: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            8'h03: return a & b;
            8'h04: return a | b;
            8'h05: return a ^ b;
            8'h06: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int gap);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_val;
        last_stop_t = $time;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        send_byte(op, 1'b1, 2);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1, 2);
        for (int i = 3; i >= 0; i--) send_byte(b[8*i +: 8], 1'b1, 2);
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] exp, input bit chk_lat);
        int          n;
        logic [31:0] w;
        bit          gaps_ok;
        bit          lat_ok;
        for (int c = 0; c < 6000 && rx_q.size() < 4; c++) @(negedge clk);
        repeat (20 * CPB) @(negedge clk);
        n = rx_q.size();
        w = 'x;
        if (n >= 4) w = {rx_q[0], rx_q[1], rx_q[2], rx_q[3]};
        gaps_ok = (n >= 4);
        for (int i = 1; i < 4 && i < n; i++)
            if (rx_t[i] - rx_t[i-1] != time'(10 * BIT_T)) gaps_ok = 1'b0;
        check({tag, "_nbytes"}, 32'(n), 32'd4);
        check({tag, "_result"}, w, exp);
        check({tag, "_backtoback"}, 32'(gaps_ok), 32'd1);
        if (chk_lat) begin
            lat_ok = (n > 0) && (rx_t[0] > last_stop_t) && (rx_t[0] - last_stop_t <= time'(LAT_MAX));
            check({tag, "_latency"}, 32'(lat_ok), 32'd1);
        end
        rx_q.delete();
        rx_t.delete();
    endtask

    initial begin : stim
        int          lows;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset and idle line
        lows = 0;
        rst  = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_tx_high", 32'(tx), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("idle_tx_low_cycles", 32'(lows), 32'd0);
        check("idle_no_bytes", 32'(rx_q.size()), 32'd0);

        // Directed opcodes
        send_packet(8'h00, 32'h0000_0005, 32'h0000_0003);
        expect_resp("add_5_3", 32'h0000_0008, 1'b1);
        send_packet(8'h01, 32'h0000_0003, 32'h0000_0005);
        expect_resp("sub_3_5", 32'hFFFF_FFFE, 1'b1);
        send_packet(8'h02, 32'h0001_0000, 32'h0001_0000);
        expect_resp("mul_wrap", 32'h0000_0000, 1'b0);
        send_packet(8'h06, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_resp("slt_signed", 32'h0000_0001, 1'b0);
        send_packet(8'h7A, 32'h1234_5678, 32'h9ABC_DEF0);
        expect_resp("bad_opcode", 32'hFFFF_FFFF, 1'b0);

        // Framing error: byte with a low stop bit must be dropped
        send_byte(8'h05, 1'b0, 3 * CPB);
        send_packet(8'h00, 32'h0000_0001, 32'h0000_0001);
        expect_resp("after_frame_err", 32'h0000_0002, 1'b0);

        // Reset in the middle of a packet
        send_byte(8'h00, 1'b1, 2);
        for (int i = 0; i < 4; i++) send_byte(8'h11, 1'b1, 2);
        repeat (50 * CPB) @(negedge clk);
        check("partial_pkt_silent", 32'(rx_q.size()), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("midpkt_reset_tx_high", 32'(tx), 32'd1);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        send_packet(8'h00, 32'h0000_0002, 32'h0000_0002);
        expect_resp("after_reset", 32'h0000_0004, 1'b0);

        // Twelve 0xFF frames, 3.2-bit gaps: frames 10-12 land while the result is still going out
        for (int i = 0; i < 12; i++) send_byte(8'hFF, 1'b1, 32);
        expect_resp("ff_stream", 32'hFFFF_FFFF, 1'b0);
        send_packet(8'h00, 32'h0000_0005, 32'h0000_0006);
        expect_resp("ff_stream_followup", 32'h0000_000B, 1'b0);

        // Random packets against the reference ALU
        for (int k = 0; k < 10; k++) begin
            op = 8'($urandom_range(0, 8));
            if (op > 8'd6) op = 8'($urandom_range(7, 255));
            a = $urandom;
            b = $urandom;
            send_packet(op, a, b);
            expect_resp($sformatf("rand%0d_op%02h", k, op), ref_alu(op, a, b), 1'b0);
        end

        check("decoder_frame_errors", 32'(dec_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
